// File: rtl/bus_target_mux_pkg.sv
// Shared types and helpers for the master-to-N-target request router.
package bus_target_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam int NARROW_W = 8;

  // Number of low data bits a target lane carries; narrow targets only see a byte.
  function automatic int lane_width(input logic narrow, input int data_w);
    return narrow ? NARROW_W : data_w;
  endfunction

endpackage

// File: rtl/bus_target_mux_timer.sv
// Stall-duration counter for a locked transaction; saturates at TIMEOUT and never wraps.
module bus_target_mux_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic start,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(1);
    end else if (inc && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/bus_target_mux.sv
// Routes one master's strobes/data to one of NUM_TGT targets, locking the target
// while it stalls and aborting with an error after TIMEOUT stalled cycles.
module bus_target_mux
  import bus_target_mux_pkg::*;
#(
  parameter int                   NUM_TGT     = 4,
  parameter int                   DATA_W      = 32,
  parameter int                   SEL_W       = $clog2(NUM_TGT),
  parameter logic [NUM_TGT-1:0]   NARROW_MASK = NUM_TGT'(1),
  parameter int                   TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEL_W-1:0]          m_sel,
  input  logic [DATA_W-1:0]         m_wdata,
  input  logic                      m_write,
  input  logic                      m_read,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_stall,
  output logic                      m_err,
  output logic [NUM_TGT*DATA_W-1:0] t_wdata,
  output logic [NUM_TGT-1:0]        t_write,
  output logic [NUM_TGT-1:0]        t_read,
  input  logic [NUM_TGT*DATA_W-1:0] t_rdata,
  input  logic [NUM_TGT-1:0]        t_stall
);

  state_t            state;
  logic [SEL_W-1:0]  lock_idx;
  logic [SEL_W-1:0]  act;
  logic              req;
  logic              rd;
  logic              sel_ok;
  logic              active;
  logic              stall_act;
  logic              expired;
  logic              tmr_start;
  logic              tmr_inc;
  logic              tmr_clear;
  logic [NUM_TGT-1:0] hit;
  logic [DATA_W-1:0]  rdata_lane [NUM_TGT];
  logic [DATA_W-1:0]  rdata_mux;

  assign req    = m_write | m_read;
  // A simultaneous read and write is illegal; the write is honoured.
  assign rd     = m_read & ~m_write;
  assign sel_ok = int'(m_sel) < NUM_TGT;
  assign act    = (state == BUSY) ? lock_idx : m_sel;
  // Outputs are gated by rst_n so they drop the instant reset asserts.
  assign active = rst_n && ((state == BUSY) || ((state == IDLE) && sel_ok));

  generate
    for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_lane
      localparam logic [DATA_W-1:0] LANE =
        {DATA_W{1'b1}} >> (DATA_W - lane_width(NARROW_MASK[gi], DATA_W));

      assign hit[gi]     = active && (act == SEL_W'(gi));
      assign t_write[gi] = hit[gi] & m_write;
      assign t_read[gi]  = hit[gi] & rd;
      assign t_wdata[gi*DATA_W +: DATA_W] = hit[gi] ? (m_wdata & LANE) : '0;
      assign rdata_lane[gi] = hit[gi] ? (t_rdata[gi*DATA_W +: DATA_W] & LANE) : '0;
    end
  endgenerate

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      rdata_mux = rdata_mux | rdata_lane[i];
    end
  end

  assign stall_act = |(hit & t_stall);
  assign m_rdata   = req ? rdata_mux : '0;
  assign m_stall   = req & stall_act;
  assign m_err     = rst_n && ((state == ABORT) || ((state == IDLE) && req && !sel_ok));

  assign tmr_start = (state == IDLE) && req && sel_ok && stall_act;
  assign tmr_inc   = (state == BUSY) && req && stall_act;
  assign tmr_clear = (state == ABORT) || ((state == BUSY) && !(req && stall_act));

  bus_target_mux_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .start   (tmr_start),
    .inc     (tmr_inc),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && sel_ok && stall_act) begin
            state    <= BUSY;
            lock_idx <= m_sel;
          end
        end
        BUSY: begin
          if (!req || !stall_act) begin
            state <= IDLE;
          end else if (expired) begin
            state <= ABORT;
          end
        end
        ABORT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_target_mux.sv
// Directed bench for bus_target_mux: a 4-target instance (TIMEOUT=4) and a 3-target instance.
module tb_bus_target_mux;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   m_sel = '0;
  logic [31:0]  m_wdata = '0;
  logic         m_write = 1'b0;
  logic         m_read = 1'b0;

  logic [31:0]  m_rdata;
  logic         m_stall;
  logic         m_err;
  logic [127:0] t_wdata;
  logic [3:0]   t_write;
  logic [3:0]   t_read;
  logic [127:0] t_rdata = '0;
  logic [3:0]   t_stall = '0;

  logic [31:0]  m_rdata3;
  logic         m_stall3;
  logic         m_err3;
  logic [95:0]  t_wdata3;
  logic [2:0]   t_write3;
  logic [2:0]   t_read3;
  logic [95:0]  t_rdata3 = '0;
  logic [2:0]   t_stall3 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_target_mux #(
    .NUM_TGT(4), .DATA_W(32), .SEL_W(2), .NARROW_MASK(4'b0001), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m_sel(m_sel), .m_wdata(m_wdata),
    .m_write(m_write), .m_read(m_read), .m_rdata(m_rdata), .m_stall(m_stall),
    .m_err(m_err), .t_wdata(t_wdata), .t_write(t_write), .t_read(t_read),
    .t_rdata(t_rdata), .t_stall(t_stall)
  );

  bus_target_mux #(
    .NUM_TGT(3), .DATA_W(32), .SEL_W(2), .NARROW_MASK(3'b001), .TIMEOUT(255)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .m_sel(m_sel), .m_wdata(m_wdata),
    .m_write(m_write), .m_read(m_read), .m_rdata(m_rdata3), .m_stall(m_stall3),
    .m_err(m_err3), .t_wdata(t_wdata3), .t_write(t_write3), .t_read(t_read3),
    .t_rdata(t_rdata3), .t_stall(t_stall3)
  );

  task automatic test_reset();
    m_sel = 2'd1; m_write = 1'b1; m_wdata = 32'hDEAD_BEEF;
    t_stall = 4'b1111; t_rdata = {4{32'h1111_1111}};
    #1;
    checks++; if (t_write !== 4'b0) begin errors++; $display("FAIL reset_t_write got %b want 0000", t_write); end
    checks++; if (t_wdata !== 128'h0) begin errors++; $display("FAIL reset_t_wdata got %h want 0", t_wdata); end
    checks++; if (m_stall !== 1'b0) begin errors++; $display("FAIL reset_m_stall got %b want 0", m_stall); end
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL reset_m_err got %b want 0", m_err); end
    checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset_m_rdata got %h want 0", m_rdata); end
    m_write = 1'b0; t_stall = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    $display("reset: checked outputs held at zero");
  endtask

  task automatic test_write_wide();
    @(negedge clk);
    m_sel = 2'd1; m_write = 1'b1; m_wdata = 32'hA5A5_1234; t_stall = 4'b0000;
    #1;
    checks++; if (t_write !== 4'b0010) begin errors++; $display("FAIL wide_t_write got %b want 0010", t_write); end
    checks++; if (t_wdata !== 128'h0000_0000_0000_0000_A5A5_1234_0000_0000) begin errors++; $display("FAIL wide_t_wdata got %h", t_wdata); end
    checks++; if (m_stall !== 1'b0 || t_read !== 4'b0) begin errors++; $display("FAIL wide_stall_read got %b/%b want 0/0000", m_stall, t_read); end
    @(negedge clk); m_write = 1'b0;
    #1;
    checks++; if (t_write !== 4'b0) begin errors++; $display("FAIL wide_release got %b want 0000", t_write); end
    $display("write_wide: sel=1 wdata=a5a51234");
  endtask

  task automatic test_narrow();
    @(negedge clk);
    m_sel = 2'd0; m_read = 1'b1;
    t_rdata = {32'h4444_4444, 32'h3333_3333, 32'h1111_1111, 32'hFFFF_FF5A};
    #1;
    checks++; if (m_rdata !== 32'h0000_005A) begin errors++; $display("FAIL narrow_rdata got %h want 0000005a", m_rdata); end
    checks++; if (t_read !== 4'b0001) begin errors++; $display("FAIL narrow_t_read got %b want 0001", t_read); end
    @(negedge clk);
    m_read = 1'b0; m_write = 1'b1; m_wdata = 32'h1234_56C3;
    #1;
    checks++; if (t_wdata !== 128'h0000_00C3) begin errors++; $display("FAIL narrow_wdata got %h want c3", t_wdata); end
    @(negedge clk);
    m_write = 1'b0; m_read = 1'b1; m_sel = 2'd1;
    #1;
    checks++; if (m_rdata !== 32'h1111_1111) begin errors++; $display("FAIL wide_rdata got %h want 11111111", m_rdata); end
    @(negedge clk); m_read = 1'b0;
    #1;
    checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL idle_rdata got %h want 0", m_rdata); end
    $display("narrow: lane 0 masked to 8 bits");
  endtask

  task automatic test_both_strobes();
    @(negedge clk);
    m_sel = 2'd1; m_write = 1'b1; m_read = 1'b1; m_wdata = 32'h0000_0077;
    #1;
    checks++; if (t_write !== 4'b0010 || t_read !== 4'b0000) begin errors++; $display("FAIL both_strobes got w=%b r=%b want 0010/0000", t_write, t_read); end
    @(negedge clk); m_write = 1'b0; m_read = 1'b0;
    $display("both_strobes: write wins");
  endtask

  task automatic test_lock();
    @(negedge clk);
    m_sel = 2'd2; m_read = 1'b1; t_stall = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (t_read !== 4'b0100 || m_stall !== 1'b1) begin errors++; $display("FAIL lock_cycle%0d got r=%b stall=%b want 0100/1", c, t_read, m_stall); end
      @(negedge clk);
      if (c == 0) m_sel = 2'd3;
    end
    t_stall = 4'b0000;
    #1;
    checks++; if (t_read !== 4'b0100 || m_stall !== 1'b0) begin errors++; $display("FAIL lock_done got r=%b stall=%b want 0100/0", t_read, m_stall); end
    checks++; if (m_rdata !== 32'h3333_3333) begin errors++; $display("FAIL lock_rdata got %h want 33333333", m_rdata); end
    @(negedge clk); m_read = 1'b0;
    #1;
    checks++; if (t_read !== 4'b0 || m_err !== 1'b0) begin errors++; $display("FAIL lock_release got r=%b err=%b", t_read, m_err); end
    $display("lock: target 2 held while m_sel moved to 3");
  endtask

  task automatic test_timeout();
    @(negedge clk);
    m_sel = 2'd1; m_read = 1'b1; t_stall = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (m_stall !== 1'b1 || t_read !== 4'b0010 || m_err !== 1'b0) begin errors++; $display("FAIL timeout_cycle%0d got stall=%b r=%b err=%b", c, m_stall, t_read, m_err); end
      @(negedge clk);
    end
    #1;
    checks++; if (m_err !== 1'b1) begin errors++; $display("FAIL abort_err got %b want 1", m_err); end
    checks++; if (t_read !== 4'b0 || m_stall !== 1'b0 || m_rdata !== 32'h0) begin errors++; $display("FAIL abort_outputs got r=%b stall=%b rdata=%h", t_read, m_stall, m_rdata); end
    @(negedge clk); t_stall = 4'b0000;
    #1;
    checks++; if (m_err !== 1'b0 || t_read !== 4'b0010 || m_rdata !== 32'h1111_1111) begin errors++; $display("FAIL after_abort got err=%b r=%b rdata=%h", m_err, t_read, m_rdata); end
    @(negedge clk); m_read = 1'b0;
    $display("timeout: abort after 5 stalled cycles");
  endtask

  task automatic test_invalid_sel();
    @(negedge clk);
    t_stall3 = 3'b111; t_stall = 4'b0000;
    m_sel = 2'd3; m_write = 1'b1; m_wdata = 32'hCAFE_F00D;
    #1;
    checks++; if (t_write3 !== 3'b0 || t_wdata3 !== 96'h0) begin errors++; $display("FAIL invalid_strobes got w=%b wd=%h", t_write3, t_wdata3); end
    checks++; if (m_err3 !== 1'b1 || m_stall3 !== 1'b0) begin errors++; $display("FAIL invalid_err got err=%b stall=%b want 1/0", m_err3, m_stall3); end
    checks++; if (m_err !== 1'b0 || t_write !== 4'b1000) begin errors++; $display("FAIL four_tgt_sel3 got err=%b w=%b want 0/1000", m_err, t_write); end
    @(negedge clk); m_write = 1'b0;
    #1;
    checks++; if (m_err3 !== 1'b0) begin errors++; $display("FAIL invalid_clear got %b want 0", m_err3); end
    t_stall3 = 3'b000;
    $display("invalid_sel: sel=3 on 3-target instance");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    m_sel = 2'd2; m_read = 1'b1; t_stall = 4'b0100;
    @(negedge clk);
    #1;
    checks++; if (m_stall !== 1'b1 || t_read !== 4'b0100) begin errors++; $display("FAIL pre_reset got stall=%b r=%b", m_stall, t_read); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (t_read !== 4'b0 || m_stall !== 1'b0 || m_err !== 1'b0) begin errors++; $display("FAIL async_drop got r=%b stall=%b err=%b", t_read, m_stall, m_err); end
    m_read = 1'b0; t_stall = 4'b0000;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    m_sel = 2'd0; m_write = 1'b1; m_wdata = 32'h0000_0042;
    #1;
    checks++; if (t_write !== 4'b0001 || t_wdata !== 128'h42 || m_stall !== 1'b0) begin errors++; $display("FAIL post_reset got w=%b wd=%h stall=%b", t_write, t_wdata, m_stall); end
    @(negedge clk); m_write = 1'b0;
    $display("async_reset: outputs dropped mid-BUSY");
  endtask

  initial begin
    test_reset();
    test_write_wide();
    test_narrow();
    test_both_strobes();
    test_lock();
    test_timeout();
    test_invalid_sel();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
